clock_period_meter: RTL and testbench



---
 rtl/clock_period_meter.sv | 185 ++++++++++++++++++
 tb/tb_clock_period_meter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// ---------------------------------------------------------------------------
// clock_period_meter
//
// Recovers the period and high time of a slow, asynchronous clock (clk_in)
// by counting CLK_50_MHz cycles between successive synchronised rising
// edges. Results feed tempo display, divider self-check and LFO rate logic.
//
// Ports:
//   CLK_50_MHz   in   system clock, everything is on its rising edge
//   reset        in   synchronous, active-high reset
//   clk_in       in   slow clock being measured (asynchronous)
//   period       out  last valid period in CLK_50_MHz cycles
//   high_time    out  cycles clk_in was high within that period
//   period_valid out  one-cycle pulse when period/high_time update
//   overflow     out  no rising edge within 2^COUNT_WIDTH-1 cycles
//   locked       out  last two periods agree within LOCK_TOL cycles
// ---------------------------------------------------------------------------
module clock_period_meter #(
   parameter int COUNT_WIDTH = 20,
   parameter int LOCK_TOL    = 2
) (
   input  logic                   CLK_50_MHz,
   input  logic                   reset,
   input  logic                   clk_in,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time,
   output logic                   period_valid,
   output logic                   overflow,
   output logic                   locked
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] LOCK_TOL_C = COUNT_WIDTH'(LOCK_TOL);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEASURE  = 2'd1,
      ST_OVERFLOW = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 next_state_s;
   logic                   sync1_r;
   logic                   sync2_r;
   logic                   prev_r;
   logic                   rise_s;
   logic                   fall_s;
   logic                   emit_s;
   logic                   saturate_s;
   logic                   has_prev_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic [COUNT_WIDTH-1:0] hcount_r;

   // Unsigned absolute difference between two periods.
   function automatic logic [COUNT_WIDTH-1:0] abs_diff(
      input logic [COUNT_WIDTH-1:0] a,
      input logic [COUNT_WIDTH-1:0] b
   );
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   // Two-flop synchroniser followed by the edge-detect history register.
   always_ff @(posedge CLK_50_MHz) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= clk_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign rise_s = sync2_r & ~prev_r;
   assign fall_s = ~sync2_r & prev_r;

   // FSM state register.
   always_ff @(posedge CLK_50_MHz) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; a rise takes priority over count saturation.
   always_comb begin
      next_state_s = state_r;
      emit_s       = 1'b0;
      saturate_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rise_s) begin
               next_state_s = ST_MEASURE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            if (rise_s) begin
               emit_s       = 1'b1;
               next_state_s = ST_MEASURE;
            end else if (count_r == COUNT_MAX) begin
               saturate_s   = 1'b1;
               next_state_s = ST_OVERFLOW;
            end else begin
               next_state_s = ST_MEASURE;
            end
         end
         ST_OVERFLOW: begin
            if (rise_s) begin
               next_state_s = ST_MEASURE;
            end else begin
               next_state_s = ST_OVERFLOW;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Counters, measurement results, overflow and lock tracking.
   always_ff @(posedge CLK_50_MHz) begin
      if (reset) begin
         count_r      <= COUNT_ZERO;
         hcount_r     <= COUNT_ZERO;
         period       <= COUNT_ZERO;
         high_time    <= COUNT_ZERO;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
         locked       <= 1'b0;
         has_prev_r   <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               hcount_r <= COUNT_ZERO;
               count_r  <= rise_s ? COUNT_ONE : COUNT_ZERO;
            end
            ST_MEASURE: begin
               if (emit_s) begin
                  period       <= count_r;
                  // A zero hcount means no fall was seen, so clk_in stayed high.
                  high_time    <= (hcount_r == COUNT_ZERO) ? count_r : hcount_r;
                  period_valid <= 1'b1;
                  overflow     <= 1'b0;
                  locked       <= has_prev_r && (abs_diff(count_r, period) <= LOCK_TOL_C);
                  has_prev_r   <= 1'b1;
                  count_r      <= COUNT_ONE;
                  hcount_r     <= COUNT_ZERO;
               end else if (saturate_s) begin
                  // Stored period/high_time are kept; next result has no predecessor.
                  overflow   <= 1'b1;
                  locked     <= 1'b0;
                  has_prev_r <= 1'b0;
               end else begin
                  count_r <= count_r + COUNT_ONE;
                  if (fall_s) begin
                     hcount_r <= count_r;
                  end
               end
            end
            ST_OVERFLOW: begin
               if (rise_s) begin
                  count_r  <= COUNT_ONE;
                  hcount_r <= COUNT_ZERO;
               end
            end
            default: begin
               count_r  <= COUNT_ZERO;
               hcount_r <= COUNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

   localparam int W   = 10;
   localparam int TOL = 2;
   localparam int MAX = (1 << W) - 1;

   logic         CLK_50_MHz = 1'b0;
   logic         reset;
   logic         clk_in;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         period_valid;
   logic         overflow;
   logic         locked;

   clock_period_meter #(.COUNT_WIDTH(W), .LOCK_TOL(TOL)) dut (
      .CLK_50_MHz   (CLK_50_MHz),
      .reset        (reset),
      .clk_in       (clk_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .overflow     (overflow),
      .locked       (locked)
   );

   always #10 CLK_50_MHz = ~CLK_50_MHz;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge CLK_50_MHz) cyc <= cyc + 1;

   // Expected measurement: period, high time, lock, and whether the previous
   // rise also produced a result (so pulse spacing must equal the period).
   typedef struct {
      int p;
      int h;
      bit lk;
      bit spaced;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model of the measured clock, kept as plain interval arithmetic.
   bit m_have_rise   = 1'b0;
   bit m_have_prev   = 1'b0;
   bit m_last_pushed = 1'b0;
   int m_high = 0;
   int m_low  = 0;
   int m_prev = 0;

   int   last_valid_cyc = -1;
   int   ovf_rise_cyc   = -1;
   logic ovf_d          = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK_50_MHz);
      #1;
   endtask

   // A rising edge of clk_in closes the previous interval.
   task automatic model_rise();
      int   p;
      int   d;
      exp_t e;
      if (m_have_rise) begin
         p = m_high + m_low;
         if (p > MAX) begin
            m_have_prev   = 1'b0;
            m_last_pushed = 1'b0;
         end else begin
            d        = (p > m_prev) ? (p - m_prev) : (m_prev - p);
            e.p      = p;
            e.h      = m_high;
            e.lk     = m_have_prev && (d <= TOL);
            e.spaced = m_last_pushed;
            exp_q.push_back(e);
            m_have_prev   = 1'b1;
            m_prev        = p;
            m_last_pushed = 1'b1;
         end
      end
      m_have_rise = 1'b1;
      m_high      = 0;
      m_low       = 0;
   endtask

   task automatic drive_cycle(input int h, input int l);
      model_rise();
      clk_in = 1'b1;
      step(h);
      m_high = h;
      clk_in = 1'b0;
      step(l);
      m_low += l;
   endtask

   task automatic hold_low(input int n);
      step(n);
      m_low += n;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"},    period,       0);
      check({tag, "_high_time"}, high_time,    0);
      check({tag, "_valid"},     period_valid, 0);
      check({tag, "_overflow"},  overflow,     0);
      check({tag, "_locked"},    locked,       0);
   endtask

   task automatic do_reset();
      check("queue_drained_before_reset", exp_q.size(), 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_all_zero("after_reset");
      exp_q.delete();
      m_have_rise   = 1'b0;
      m_have_prev   = 1'b0;
      m_last_pushed = 1'b0;
   endtask

   // Checks every period_valid pulse against the next expected measurement.
   always @(negedge CLK_50_MHz) begin
      if (period_valid === 1'b1) begin
         check("pulse_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("period",         period,    mon_e.p);
            check("high_time",      high_time, mon_e.h);
            check("locked",         locked,    mon_e.lk);
            check("overflow_clear", overflow,  0);
            if (mon_e.spaced) begin
               check("pulse_spacing", cyc - last_valid_cyc, mon_e.p);
            end
         end
         last_valid_cyc = cyc;
      end
      if (overflow === 1'b1 && ovf_d !== 1'b1) begin
         ovf_rise_cyc = cyc;
      end
      ovf_d = overflow;
   end

   initial begin
      int p;
      int h;
      int prev_p;
      reset  = 1'b1;
      clk_in = 1'b0;
      step(3);
      check_all_zero("reset_state");
      reset = 1'b0;
      step(2);

      // 50% duty: first result unlocked, second locked.
      repeat (3) drive_cycle(200, 200);
      // Minimum 2-high / 2-low period.
      repeat (6) drive_cycle(2, 2);
      // 25% duty.
      repeat (3) drive_cycle(150, 450);
      // Lock tolerance boundary: diff 3 unlocks, diff 2 locks.
      drive_cycle(50, 50);
      drive_cycle(50, 53);
      drive_cycle(50, 50);
      drive_cycle(50, 52);
      drive_cycle(50, 50);

      // Stop clk_in low after a valid measurement.
      drive_cycle(100, 100);
      drive_cycle(100, 100);
      ovf_rise_cyc = -1;
      hold_low(MAX + 20);
      check("ovf_set",        overflow, 1);
      check("ovf_locked",     locked,   0);
      check("ovf_period_hold", period,  200);
      check("ovf_latency",    ovf_rise_cyc - last_valid_cyc, MAX);
      drive_cycle(30, 30);
      check("ovf_still_set", overflow, 1);
      drive_cycle(30, 30);
      drive_cycle(30, 30);

      // Saturation and rise together: period of exactly MAX is accepted.
      drive_cycle(600, MAX - 600);
      drive_cycle(2, 2);
      drive_cycle(512, 512);
      drive_cycle(2, 2);
      drive_cycle(2, 2);
      drive_cycle(2, 2);

      // Reset mid-period, then restart.
      drive_cycle(80, 40);
      hold_low(20);
      do_reset();
      repeat (3) drive_cycle(70, 70);

      // Randomised periods, half of them close to the previous one.
      prev_p = 140;
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            p = prev_p + $urandom_range(6, 0) - 3;
         end else begin
            p = $urandom_range(800, 8);
         end
         h = $urandom_range(p - 2, 2);
         drive_cycle(h, p - h);
         prev_p = p;
      end
      drive_cycle(2, 2);
      step(10);
      check("queue_drained_at_end", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
